alu_cmd_queue: RTL and testbench
================================

Name: alu_cmd_queue

Overview:
- Command buffer directly upstream of the ALU stage.
- Accepts ALU commands {select, a, b} from a producer over a valid/ready handshake and stores them in a small synchronous FIFO.
- Issues them in order to the ALU over a second valid/ready handshake, decoupling producer timing from ALU consumption.
- Opcode encoding: 00 pass a, 01 a+b, 10 a-b, 11 a+1.

Parameters:
- DEPTH, 4, number of command entries; must be a power of 2, at least 2.
- OPW, 5, operand width of a and b.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a command.
- in_ready  output  1  queue can accept; equals not full.
- in_select  input  2  opcode.
- in_a  input  OPW  operand a.
- in_b  input  OPW  operand b.
- out_valid  output  1  command at head available to ALU.
- out_ready  input  1  ALU consumes head this cycle.
- out_select  output  2  head opcode.
- out_a  output  OPW  head operand a.
- out_b  output  OPW  head operand b.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, sampled on the clock edge with rst_n=0:
  - Write pointer, read pointer and count go to 0.
  - out_valid=0, in_ready=1.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all queued commands; no handshake completes in the reset cycle.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It is never a function of out_ready, so there is no combinational ready path.
- out_valid = (count != 0).
- out_select, out_a and out_b show the head entry when out_valid=1, and are forced to 0 when out_valid=0.
- Latency: a command pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
- Counters and pointers:
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Boundary cases:
  - Full: in_ready=0. A push is refused even if a pop happens in the same cycle.
  - Empty: out_valid=0. out_ready is ignored and the pointers do not move.
  - Simultaneous push and pop when 0 < count < DEPTH: both complete, count is unchanged, and order is preserved.
  - in_valid while in_ready=0: the command is not taken. The producer must hold it.
  - Outputs are stable while out_valid && !out_ready. The head does not change until popped.
- No arithmetic is performed. Operands pass through bit-exact. Opcode values are not checked.

Optional Feature:
- Macro: ALU_CMD_QUEUE_BYPASS_EN.
- With the macro defined:
  - When count==0, in_valid=1 and out_ready=1, the command goes combinationally from in_* to out_* with out_valid=1 in the same cycle.
  - The command is not written to storage, and count stays 0.
  - If out_ready=0 in that situation, the command is stored normally.
- Without the macro: no bypass. Minimum latency is 1 cycle, and out_* never depends combinationally on in_*.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_PASS_A=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_INC=2'b11.
  - Default operand width constant ALU_OPW=5.
  - A packed command typedef alu_cmd_t {select[1:0], a[OPW-1:0], b[OPW-1:0]}.
- One sub-module, alu_cmd_fifo_mem: a DEPTH x (2+2*OPW) register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stay in the top module.

Test Plan:
1. Reset then single command: push {01, 5'd5, 5'd2} with out_ready=0 -> next cycle out_valid=1, out_select=01, out_a=5, out_b=2, count=1; raise out_ready -> count=0, out_valid=0, outputs 0.
2. Fill to full: push 4 commands a=1..4 with out_ready=0 -> count=4, in_ready=0; a fifth push with in_valid=1 is not accepted. Then drain -> a emerges 1,2,3,4 in order.
3. Simultaneous push and pop at count=2: push {11, 5'd7, 5'd0} while popping -> count stays 2; the popped head is the oldest entry; the new entry emerges last.
4. Full plus pop in the same cycle: in_valid=1, out_ready=1, count=4 -> pop completes, push refused, count=3, in_ready=1 next cycle.
5. Pointer wrap: 10 push/pop pairs with a=0..9 -> output sequence 0..9, no loss or duplication.
6. Reset mid-stream: count=3, assert rst_n=0 for one cycle -> count=0, out_valid=0, in_ready=1. With ALU_CMD_QUEUE_BYPASS_EN defined, an empty-queue push of {00, 5'd5, 5'd2} with out_ready=1 appears the same cycle and count stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default operand width and the
// packed command layout used between the command queue and the ALU stage.
package alu_pkg;

    localparam logic [1:0] OP_PASS_A = 2'b00;
    localparam logic [1:0] OP_ADD    = 2'b01;
    localparam logic [1:0] OP_SUB    = 2'b10;
    localparam logic [1:0] OP_INC    = 2'b11;

    localparam int ALU_OPW = 5;

    // Field order matches the flat {select, a, b} vector stored in the queue.
    typedef struct packed {
        logic [1:0]         select;
        logic [ALU_OPW-1:0] a;
        logic [ALU_OPW-1:0] b;
    } alu_cmd_t;

    // Bit width of one stored command for a given operand width.
    function automatic int cmd_width(input int opw);
        return 2 + 2 * opw;
    endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Producer-side and ALU-side handshake bundle for alu_cmd_queue.
// The master modport is the environment (producer + ALU); slave is the queue.
interface alu_cmd_queue_if
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = ALU_OPW
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_select;
    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;

    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_select;
    logic [OPW-1:0] out_a;
    logic [OPW-1:0] out_b;

    logic [CW-1:0]  count;

    modport master (
        output in_valid, in_select, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_select, out_a, out_b, count
    );

    modport slave (
        input  in_valid, in_select, in_a, in_b, out_ready,
        output in_ready, out_valid, out_select, out_a, out_b, count
    );

endinterface

// File: rtl/alu_cmd_fifo_mem.sv
// Command storage for alu_cmd_queue: DEPTH x WIDTH register array with one
// synchronous write port and one asynchronous (combinational) read port.
module alu_cmd_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on a push.
    // NOTE: storage has no reset; an entry is only ever read after it was written, so clearing it would just cost a reset net on every bit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_cmd_queue.sv
// In-order ALU command buffer: valid/ready in, valid/ready out, DEPTH entries.
// in_ready depends only on occupancy, never on out_ready.
// Optional: define ALU_CMD_QUEUE_BYPASS_EN to let a command flow straight
// through in the same cycle when the queue is empty and the ALU is ready.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = ALU_OPW
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_cmd_queue_if.slave bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CMDW = cmd_width(OPW);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            full;
    logic            empty;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [CMDW-1:0] wr_cmd;
    logic [CMDW-1:0] head_cmd;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_cmd = {bus.in_select, bus.in_a, bus.in_b};

`ifdef ALU_CMD_QUEUE_BYPASS_EN
    // Empty queue with a ready ALU: hand the command over directly.
    assign bypass = empty & bus.in_valid & bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed command is consumed by the ALU and never occupies a slot.
    assign push = bus.in_valid & ~full & ~bypass;
    assign pop  = ~empty & bus.out_ready;

    alu_cmd_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (CMDW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & rst_n),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_cmd),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_cmd)
    );

    // Next-state for pointers and occupancy from the push/pop decisions.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; reset drops all queued commands.
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Handshake flags and head presentation; payload is zero when nothing is valid.
    always_comb begin
        bus.in_ready  = ~full;
        bus.count     = count_q;
        bus.out_valid = ~empty | bypass;
        {bus.out_select, bus.out_a, bus.out_b} = '0;
        if (bypass) begin
            {bus.out_select, bus.out_a, bus.out_b} = wr_cmd;
        end else if (!empty) begin
            {bus.out_select, bus.out_a, bus.out_b} = head_cmd;
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue. A queue-based reference model
// predicts occupancy, flags and head payload every cycle; scenario tasks add
// directed expectations for the documented corner cases.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int OPW   = ALU_OPW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_cmd_queue_if #(.DEPTH(DEPTH), .OPW(OPW)) bus ();

    alu_cmd_queue #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: commands currently held, oldest first.
    alu_cmd_t mq[$];

    // Observed and expected {in_ready, out_valid, select, a, b, count}.
    logic [16:0] obs_vec, exp_vec;
    logic        o_ir, o_ov;
    logic [1:0]  o_sel;
    logic [4:0]  o_a, o_b;
    logic [2:0]  o_cnt;

    // One clock cycle: drive at negedge, sample 1ns later, advance model at posedge.
    task automatic cycle(input logic iv, input logic [1:0] sel, input logic [4:0] a,
                         input logic [4:0] b, input logic ore);
        alu_cmd_t cmd, head;
        int       n;
        logic     byp, do_push, do_pop;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.in_valid  = iv;
        bus.in_select = sel;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ore;
        #1;
        cmd = {sel, a, b};
        n   = mq.size();
`ifdef ALU_CMD_QUEUE_BYPASS_EN
        byp = (n == 0) && iv && ore;
`else
        byp = 1'b0;
`endif
        if (byp)         head = cmd;
        else if (n != 0) head = mq[0];
        else             head = '0;
        exp_vec = {(n != DEPTH), ((n != 0) || byp), head, 3'(n)};
        o_ir  = bus.in_ready;
        o_ov  = bus.out_valid;
        o_sel = bus.out_select;
        o_a   = bus.out_a;
        o_b   = bus.out_b;
        o_cnt = bus.count;
        obs_vec = {o_ir, o_ov, o_sel, o_a, o_b, o_cnt};
        do_pop  = (n != 0) && ore;
        do_push = iv && (n != DEPTH) && !byp;
        @(posedge clk);
        if (do_pop)  mq.delete(0);
        if (do_push) mq.push_back(cmd);
    endtask

    // Hold rst_n low for one edge while driving the given handshake inputs.
    task automatic do_reset(input logic iv, input logic ore);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = iv;
        bus.in_select = 2'b01;
        bus.in_a      = 5'($urandom);
        bus.in_b      = 5'($urandom);
        bus.out_ready = ore;
        @(posedge clk);
        mq.delete();
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ir, o_ov, o_cnt} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_flags: got ir/ov/cnt %b/%b/%0d want 1/0/0", o_ir, o_ov, o_cnt);
        end
        n_checks++;
        if ({o_sel, o_a, o_b} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_payload: got %h want 000", {o_sel, o_a, o_b});
        end
    endtask

    task automatic test_single();
        cycle(1'b1, OP_ADD, 5'd5, 5'd2, 1'b0);
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ov, o_sel, o_a, o_b, o_cnt} !== {1'b1, 2'b01, 5'd5, 5'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL single_visible: got ov=%b sel=%b a=%0d b=%0d cnt=%0d want 1/01/5/2/1",
                     o_ov, o_sel, o_a, o_b, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ov, o_sel, o_a, o_b, o_cnt} !== 16'd0) begin
            n_fail++;
            $display("FAIL single_drained: got ov=%b payload=%h cnt=%0d want 0/000/0",
                     o_ov, {o_sel, o_a, o_b}, o_cnt);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 2'($urandom), 5'(i), 5'($urandom), 1'b0);
        cycle(1'b1, OP_SUB, 5'd5, 5'd9, 1'b0);
        n_checks++;
        if ({o_ir, o_cnt} !== {1'b0, 3'd4} || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL full_flags: got ir=%b cnt=%0d vec=%h want ir=0 cnt=4 vec=%h",
                     o_ir, o_cnt, obs_vec, exp_vec);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if (o_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL full_refuse: got cnt=%0d want 4", o_cnt);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
            n_checks++;
            if (o_a !== 5'(i) || obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL full_drain_order: got a=%0d vec=%h want a=%0d vec=%h",
                         o_a, obs_vec, i, exp_vec);
            end
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, OP_PASS_A, 5'd20, 5'd1, 1'b0);
        cycle(1'b1, OP_ADD,    5'd21, 5'd2, 1'b0);
        cycle(1'b1, OP_INC,    5'd7,  5'd0, 1'b1);
        n_checks++;
        if ({o_a, o_cnt} !== {5'd20, 3'd2}) begin
            n_fail++;
            $display("FAIL simul_pop_oldest: got a=%0d cnt=%0d want 20/2", o_a, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        n_checks++;
        if ({o_a, o_cnt} !== {5'd21, 3'd2}) begin
            n_fail++;
            $display("FAIL simul_count_held: got a=%0d cnt=%0d want 21/2", o_a, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        n_checks++;
        if ({o_sel, o_a, o_b, o_cnt} !== {2'b11, 5'd7, 5'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL simul_new_last: got sel=%b a=%0d b=%0d cnt=%0d want 11/7/0/1",
                     o_sel, o_a, o_b, o_cnt);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'($urandom), 5'(10 + i), 5'($urandom), 1'b0);
        cycle(1'b1, OP_ADD, 5'd31, 5'd31, 1'b1);
        n_checks++;
        if ({o_ir, o_a, o_cnt} !== {1'b0, 5'd10, 3'd4}) begin
            n_fail++;
            $display("FAIL fullpop_edge: got ir=%b a=%0d cnt=%0d want 0/10/4", o_ir, o_a, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ir, o_a, o_cnt} !== {1'b1, 5'd11, 3'd3}) begin
            n_fail++;
            $display("FAIL fullpop_after: got ir=%b a=%0d cnt=%0d want 1/11/3", o_ir, o_a, o_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL fullpop_drain: got %h want %h", obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] got[$];
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'($urandom), 5'(i), 5'($urandom), 1'b1);
            if (o_ov) got.push_back(o_a);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
            if (o_ov) got.push_back(o_a);
        end
        n_checks++;
        if (got.size() != 10) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d issued want 10", got.size());
        end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_checks++;
            if (got[i] !== 5'(i)) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got a=%0d want %0d", i, got[i], i);
            end
        end
    endtask

    task automatic test_random();
        logic iv, ore;
        for (int i = 0; i < 300; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            ore = ($urandom_range(0, 2) != 0);
            if (i >= 150) ore = ($urandom_range(0, 3) == 0);
            cycle(iv, 2'($urandom), 5'($urandom), 5'($urandom), ore);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        for (int k = 0; k < 6; k++) cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'($urandom), 5'(i + 3), 5'($urandom), 1'b0);
        do_reset(1'b1, 1'b1);
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ir, o_ov, o_cnt} !== {1'b1, 1'b0, 3'd0} || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL midreset_flags: got ir/ov/cnt %b/%b/%0d want 1/0/0", o_ir, o_ov, o_cnt);
        end
        cycle(1'b1, OP_PASS_A, 5'd5, 5'd2, 1'b1);
`ifdef ALU_CMD_QUEUE_BYPASS_EN
        n_checks++;
        if ({o_ov, o_sel, o_a, o_b, o_cnt} !== {1'b1, 2'b00, 5'd5, 5'd2, 3'd0}) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got ov=%b sel=%b a=%0d b=%0d cnt=%0d want 1/00/5/2/0",
                     o_ov, o_sel, o_a, o_b, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ov, o_cnt} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL bypass_not_stored: got ov=%b cnt=%0d want 0/0", o_ov, o_cnt);
        end
`else
        n_checks++;
        if ({o_ov, o_sel, o_a, o_b, o_cnt} !== 16'd0) begin
            n_fail++;
            $display("FAIL nobypass_latency: got ov=%b payload=%h cnt=%0d want 0/000/0",
                     o_ov, {o_sel, o_a, o_b}, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1);
        n_checks++;
        if ({o_ov, o_sel, o_a, o_b, o_cnt} !== {1'b1, 2'b00, 5'd5, 5'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL nobypass_next_cycle: got ov=%b sel=%b a=%0d b=%0d cnt=%0d want 1/00/5/2/1",
                     o_ov, o_sel, o_a, o_b, o_cnt);
        end
        cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        n_checks++;
        if ({o_ov, o_cnt} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL nobypass_drained: got ov=%b cnt=%0d want 0/0", o_ov, o_cnt);
        end
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_select = 2'b00;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_full();
        test_simultaneous();
        test_full_pop();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
